row_bound_scanner: RTL and testbench
====================================

# row_bound_scanner

Scans one binary-image row, held as WORDS_PER_ROW 32-bit words in a synchronous row RAM, for the leftmost and rightmost set pixel. It walks words from the left to find the first non-zero word, then from the right to find the last non-zero word. Each hit word goes to the 32-bit bound detector stage directly downstream (left mode, then right mode). The block converts the returned in-word indices into absolute row columns for the connected-domain filter.

## Interface
- WORDS_PER_ROW, 20, number of 32-bit words per row (2..2^ADDR_W)
- ADDR_W, 5, row RAM address width
- i_clk  in  1  clock
- i_rstn  in  1  reset, asynchronous, active-low
- i_start  in  1  start a row scan; sampled only in IDLE
- o_busy  out  1  high in every state except IDLE
- o_rd_en  out  1  row RAM read strobe
- o_rd_addr  out  ADDR_W  row RAM word address
- i_rd_data  in  32  RAM data, valid the cycle after o_rd_en
- o_det_trig  out  1  detector request level
- o_det_data  out  32  word under test, stable while o_det_trig high
- o_det_left_or_right  out  1  0 = left bound, 1 = right bound
- i_det_index  in  5  detector bound index
- i_det_detected  in  1  detector found a bound
- i_det_done  in  1  detector result valid (level)
- o_left_col  out  ADDR_W+5  absolute leftmost column
- o_right_col  out  ADDR_W+5  absolute rightmost column
- o_row_valid  out  1  row contains at least one set pixel
- o_err  out  1  one-cycle pulse on aborted handshake
- o_done  out  1  one-cycle pulse, row result valid

## Operation
- Pixel mapping: bit b of word w is column 32*w + b.
- States: IDLE, L_RD, L_CHK, L_TRIG, L_REL, R_RD, R_CHK, R_TRIG, R_REL, DONE.
- IDLE: on i_start, clear word pointer to 0 and go to L_RD.
- L_RD: o_rd_en=1, o_rd_addr=pointer, then go to L_CHK.
- L_CHK: if i_rd_data != 0, latch it and the left word index into o_det_data and go to L_TRIG.
- L_CHK, word zero and not last: increment the pointer and go to L_RD.
- L_CHK, zero and last word: o_row_valid=0, o_left_col=o_right_col=0, go to DONE.
- L_TRIG: o_det_trig=1, o_det_left_or_right=0; wait for i_det_done=1.
- On i_det_done: if i_det_detected, o_left_col = 32*wl + i_det_index; otherwise o_row_valid=0 and go to DONE.
- L_REL: o_det_trig=0; wait for i_det_done=0, set the pointer to WORDS_PER_ROW-1, go to R_RD.
- R_RD/R_CHK: same as the left scan but the pointer decrements. The scan stops at the first non-zero word; it never passes wl, which is guaranteed non-zero.
- R_TRIG/R_REL: same as the left handshake with o_det_left_or_right=1. On done: o_right_col = 32*wr + (31 - i_det_index), o_row_valid=1.
- DONE: o_done=1 for one cycle, then return to IDLE.
- Column results and o_row_valid hold until the next i_start.
- Handshake is four-phase: trig rises, done rises, trig falls, done falls. o_det_data and o_det_left_or_right change only while o_det_trig=0 and i_det_done=0.
- i_start while busy: ignored. i_start in the DONE cycle: ignored.
- Column arithmetic is unsigned ADDR_W+5 bits; no overflow for legal WORDS_PER_ROW.

## Timing
- Reset: state IDLE, pointer 0; all outputs 0.
- Reset mid-scan or mid-handshake: immediate return to IDLE, o_det_trig drops asynchronously, no o_done.
- RAM read latency is exactly 1 cycle; each word costs 2 cycles (RD, CHK).
- All-zero row: o_done high exactly 2*WORDS_PER_ROW+1 cycles after the i_start sampling edge.
- Row with bounds in wl, wr and detector latencies Dl, Dr (trig-to-done plus done-fall): o_done exactly 2*(wl+1) + 2*(WORDS_PER_ROW-wr) + Dl + Dr + 5 cycles after the start edge.
- o_left_col, o_right_col and o_row_valid are valid no later than the cycle o_done is high.

## Configuration
- ROW_BOUND_TIMEOUT_EN defined: an 8-bit watchdog runs in each TRIG/REL state and reloads on state entry.
- Watchdog expiry after 255 cycles without the awaited i_det_done level:
  - o_det_trig drops.
  - o_err pulses for one cycle.
  - o_row_valid=0 and o_left_col=o_right_col=0.
  - o_done pulses in the following cycle, then the block returns to IDLE.
- Not defined: no watchdog, the handshake waits indefinitely, o_err is tied 0.

## Test plan
- All 20 words 0, start -> 20 left-scan reads (addr 0..19), no o_det_trig, o_done at cycle 41, o_row_valid=0, columns 0.
- Word 3 = 0x0000_0100, rest 0; detector model returns index 8 (left) and 23 (right) -> o_left_col=104, o_right_col=104, o_row_valid=1; right-scan reads addr 19..3.
- Word 0 = 0x8000_0000, word 19 = 0x0000_0001; model returns left index 31 and right index 31 -> o_left_col=31, o_right_col=608.
- Model with 10-cycle done delay, i_start pulsed during L_TRIG -> second start ignored; o_det_data stable while trig high; exactly one o_done.
- Assert i_rstn low during R_TRIG -> o_det_trig=0 immediately, all outputs 0, no o_done; a fresh start after release gives correct results.
- With ROW_BOUND_TIMEOUT_EN and i_det_done stuck 0 -> o_err pulse 255 cycles after L_TRIG entry, o_done next cycle, o_row_valid=0.

Source files
------------

// File: rtl/row_bound_scanner.sv
// Row bound scanner: finds the leftmost and rightmost set pixel of one image row
// stored in a word RAM, using the downstream 32-bit bound detector.
// Optional handshake watchdog enabled by defining ROW_BOUND_TIMEOUT_EN.
module row_bound_scanner #(
  parameter int WORDS_PER_ROW = 20,
  parameter int ADDR_W        = 5
) (
  input  logic              i_clk,
  input  logic              i_rstn,
  input  logic              i_start,
  output logic              o_busy,
  output logic              o_rd_en,
  output logic [ADDR_W-1:0] o_rd_addr,
  input  logic [31:0]       i_rd_data,
  output logic              o_det_trig,
  output logic [31:0]       o_det_data,
  output logic              o_det_left_or_right,
  input  logic [4:0]        i_det_index,
  input  logic              i_det_detected,
  input  logic              i_det_done,
  output logic [ADDR_W+4:0] o_left_col,
  output logic [ADDR_W+4:0] o_right_col,
  output logic              o_row_valid,
  output logic              o_err,
  output logic              o_done
);

  typedef enum logic [3:0] {
    IDLE, L_RD, L_CHK, L_TRIG, L_REL, R_RD, R_CHK, R_TRIG, R_REL, DONE, ABORT
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_WORD = ADDR_W'(WORDS_PER_ROW - 1);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [31:0]       data_q, data_d;
  logic [ADDR_W+4:0] lcol_q, lcol_d, rcol_q, rcol_d;
  logic              valid_q, valid_d;
  logic              wd_expired;

`ifdef ROW_BOUND_TIMEOUT_EN
  logic [7:0] wd_q;
  logic       wd_waiting;

  assign wd_waiting = (state_q == L_TRIG) || (state_q == L_REL) ||
                      (state_q == R_TRIG) || (state_q == R_REL);
  // The counter holds 0 in the first cycle of a waiting state, so 254 marks
  // the 255th cycle without the awaited done level.
  assign wd_expired = wd_waiting && (wd_q == 8'd254);
  assign o_err      = (state_q == ABORT);

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn)                                wd_q <= '0;
    else if (!wd_waiting || state_d != state_q) wd_q <= '0;
    else                                        wd_q <= wd_q + 8'd1;
  end
`else
  assign wd_expired = 1'b0;
  assign o_err      = 1'b0;
`endif

  // NOTE: every registered value uses <= so all updates see pre-edge state.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      data_q  <= '0;
      lcol_q  <= '0;
      rcol_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      data_q  <= data_d;
      lcol_q  <= lcol_d;
      rcol_q  <= rcol_d;
      valid_q <= valid_d;
    end
  end

  // NOTE: hold values are assigned first so no path through the case infers a latch.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    data_d  = data_q;
    lcol_d  = lcol_q;
    rcol_d  = rcol_q;
    valid_d = valid_q;
    case (state_q)
      IDLE: if (i_start) begin
        ptr_d   = '0;
        lcol_d  = '0;
        rcol_d  = '0;
        valid_d = 1'b0;
        state_d = L_RD;
      end
      L_RD:  state_d = L_CHK;
      L_CHK: begin
        if (i_rd_data != '0) begin
          data_d  = i_rd_data;
          state_d = L_TRIG;
        end else if (ptr_q == LAST_WORD) begin
          state_d = DONE;
        end else begin
          ptr_d   = ptr_q + ADDR_W'(1);
          state_d = L_RD;
        end
      end
      L_TRIG: begin
        if (i_det_done) begin
          if (i_det_detected) begin
            lcol_d  = {ptr_q, i_det_index};
            state_d = L_REL;
          end else begin
            valid_d = 1'b0;
            state_d = DONE;
          end
        end else if (wd_expired) begin
          state_d = ABORT;
        end
      end
      L_REL: begin
        if (!i_det_done) begin
          ptr_d   = LAST_WORD;
          state_d = R_RD;
        end else if (wd_expired) begin
          state_d = ABORT;
        end
      end
      R_RD:  state_d = R_CHK;
      R_CHK: begin
        // The left hit word bounds this walk; the zero check only guards address wrap.
        if (i_rd_data != '0) begin
          data_d  = i_rd_data;
          state_d = R_TRIG;
        end else if (ptr_q == '0) begin
          state_d = DONE;
        end else begin
          ptr_d   = ptr_q - ADDR_W'(1);
          state_d = R_RD;
        end
      end
      R_TRIG: begin
        if (i_det_done) begin
          if (i_det_detected) begin
            // Right-mode index counts from the MSB, so 31 - index is its bitwise inverse.
            rcol_d  = {ptr_q, ~i_det_index};
            valid_d = 1'b1;
            state_d = R_REL;
          end else begin
            valid_d = 1'b0;
            state_d = DONE;
          end
        end else if (wd_expired) begin
          state_d = ABORT;
        end
      end
      R_REL: begin
        if (!i_det_done)     state_d = DONE;
        else if (wd_expired) state_d = ABORT;
      end
      DONE:  state_d = IDLE;
      ABORT: begin
        lcol_d  = '0;
        rcol_d  = '0;
        valid_d = 1'b0;
        state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign o_busy              = (state_q != IDLE);
  assign o_rd_en             = (state_q == L_RD) || (state_q == R_RD);
  assign o_rd_addr           = ptr_q;
  assign o_det_trig          = (state_q == L_TRIG) || (state_q == R_TRIG);
  assign o_det_data          = data_q;
  assign o_det_left_or_right = (state_q == R_RD) || (state_q == R_CHK) ||
                               (state_q == R_TRIG) || (state_q == R_REL);
  assign o_left_col          = lcol_q;
  assign o_right_col         = rcol_q;
  assign o_row_valid         = valid_q;
  assign o_done              = (state_q == DONE);

endmodule

// File: tb/tb_row_bound_scanner.sv
// Self-checking bench for row_bound_scanner: row RAM and bound detector models,
// table vectors, random rows against a pixel-level reference, and corner sequences.
module tb_row_bound_scanner;
  localparam int W  = 20;
  localparam int AW = 5;
  localparam int CW = AW + 5;

  logic          i_clk = 1'b0;
  logic          i_rstn = 1'b0;
  logic          i_start = 1'b0;
  logic          o_busy, o_rd_en;
  logic [AW-1:0] o_rd_addr;
  logic [31:0]   i_rd_data = '0;
  logic          o_det_trig;
  logic [31:0]   o_det_data;
  logic          o_det_left_or_right;
  logic [4:0]    i_det_index;
  logic          i_det_detected, i_det_done;
  logic [CW-1:0] o_left_col, o_right_col;
  logic          o_row_valid, o_err, o_done;

  always #5 i_clk = ~i_clk;

  row_bound_scanner #(.WORDS_PER_ROW(W), .ADDR_W(AW)) dut (
    .i_clk(i_clk), .i_rstn(i_rstn), .i_start(i_start), .o_busy(o_busy),
    .o_rd_en(o_rd_en), .o_rd_addr(o_rd_addr), .i_rd_data(i_rd_data),
    .o_det_trig(o_det_trig), .o_det_data(o_det_data),
    .o_det_left_or_right(o_det_left_or_right), .i_det_index(i_det_index),
    .i_det_detected(i_det_detected), .i_det_done(i_det_done),
    .o_left_col(o_left_col), .o_right_col(o_right_col),
    .o_row_valid(o_row_valid), .o_err(o_err), .o_done(o_done)
  );

  int tests = 0;
  int fails = 0;

  // Row RAM with one cycle of read latency; every read address is logged.
  logic [31:0] row_mem [W];
  int rd_log[$];
  always @(posedge i_clk) begin
    if (o_rd_en) begin
      i_rd_data <= row_mem[o_rd_addr];
      rd_log.push_back(int'(o_rd_addr));
    end
  end

  // Detector: done follows trig delayed by det_k cycles; index is the trailing
  // zero count (left mode) or leading zero count (right mode).
  int          det_k = 1;
  logic        det_stuck = 1'b0;
  logic [15:0] trig_hist = '0;
  always @(posedge i_clk) trig_hist <= {trig_hist[14:0], o_det_trig};
  assign i_det_done = det_stuck ? 1'b0 : trig_hist[det_k-1];
  always_comb begin
    i_det_detected = (o_det_data != '0);
    i_det_index    = '0;
    if (!o_det_left_or_right) begin
      for (int b = 31; b >= 0; b--) if (o_det_data[b]) i_det_index = 5'(b);
    end else begin
      for (int b = 0; b < 32; b++) if (o_det_data[b]) i_det_index = 5'(31 - b);
    end
  end

  // Event monitors sampled on the falling edge.
  int          done_pulses = 0, err_pulses = 0, proto_errs = 0;
  logic [31:0] prev_data = '0;
  logic        prev_lr = 1'b0, prev_trig = 1'b0, prev_done = 1'b0;
  always @(negedge i_clk) begin
    if (o_done) done_pulses++;
    if (o_err)  err_pulses++;
    if ((o_det_data != prev_data || o_det_left_or_right != prev_lr) && (prev_trig || prev_done))
      proto_errs++;
    prev_data = o_det_data;
    prev_lr   = o_det_left_or_right;
    prev_trig = o_det_trig;
    prev_done = i_det_done;
  end

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Reference: bound columns straight from the pixel definition.
  task automatic model(output int l, output int r, output bit v);
    l = 0; r = 0; v = 1'b0;
    for (int c = W*32 - 1; c >= 0; c--) if (row_mem[c/32][c%32]) begin l = c; v = 1'b1; end
    for (int c = 0; c < W*32; c++) if (row_mem[c/32][c%32]) r = c;
  endtask

  function automatic int exp_cycles(input int l, input int r, input bit v, input int k);
    if (!v) return 2*W + 1;
    return 2*(l/32 + 1) + 2*(W - r/32) + 4*k + 5;
  endfunction

  task automatic clear_row();
    for (int i = 0; i < W; i++) row_mem[i] = '0;
  endtask

  // One full scan; inject=1 pulses i_start during the first trig cycle and in the DONE cycle.
  task automatic run_row(input string tag, input int k, input int exp_l, input int exp_r,
                         input bit exp_v, input int exp_cyc, input bit inject);
    int cyc;
    bit pulsed;
    bit ok;
    int exp_addr[$];
    if (exp_v) begin
      for (int a = 0; a <= exp_l/32; a++) exp_addr.push_back(a);
      for (int a = W-1; a >= exp_r/32; a--) exp_addr.push_back(a);
    end else begin
      for (int a = 0; a < W; a++) exp_addr.push_back(a);
    end
    det_k = k;
    rd_log.delete();
    @(negedge i_clk);
    done_pulses = 0; err_pulses = 0; proto_errs = 0;
    i_start = 1'b1;
    @(posedge i_clk);
    #1 i_start = 1'b0;
    cyc = 0;
    pulsed = 1'b0;
    while (cyc < 3000) begin
      @(negedge i_clk);
      cyc++;
      i_start = 1'b0;
      if (inject && o_det_trig && !pulsed) begin
        i_start = 1'b1;
        pulsed = 1'b1;
      end
      if (o_done) begin
        if (inject) i_start = 1'b1;
        break;
      end
    end
    check({tag, " done_cycle"}, cyc, exp_cyc);
    check({tag, " left_col"}, int'(o_left_col), exp_l);
    check({tag, " right_col"}, int'(o_right_col), exp_r);
    check({tag, " row_valid"}, int'(o_row_valid), int'(exp_v));
    @(negedge i_clk);
    i_start = 1'b0;
    repeat (3) @(negedge i_clk);
    check({tag, " idle_after"}, int'(o_busy), 0);
    check({tag, " done_pulses"}, done_pulses, 1);
    check({tag, " err_pulses"}, err_pulses, 0);
    check({tag, " handshake"}, proto_errs, 0);
    ok = (rd_log.size() == exp_addr.size());
    if (ok) foreach (exp_addr[i]) if (rd_log[i] != exp_addr[i]) ok = 1'b0;
    check({tag, " rd_addrs"}, int'(ok), 1);
    repeat (16) @(negedge i_clk);
  endtask

  typedef struct {
    int          w_a;
    logic [31:0] d_a;
    int          w_b;
    logic [31:0] d_b;
    int          k;
    int          exp_l;
    int          exp_r;
    bit          exp_v;
    int          exp_cyc;
  } vec_t;

  initial begin
    vec_t vecs[6];
    int   l, r, cyc;
    bit   v;

    vecs[0] = '{-1, 32'h0,         -1, 32'h0,         1, 0,   0,   1'b0, 41};
    vecs[1] = '{ 3, 32'h0000_0100, -1, 32'h0,         1, 104, 104, 1'b1, 51};
    vecs[2] = '{ 0, 32'h8000_0000, 19, 32'h0000_0001, 1, 31,  608, 1'b1, 13};
    vecs[3] = '{ 7, 32'h0001_0000, 12, 32'h8000_0000, 3, 240, 415, 1'b1, 49};
    vecs[4] = '{19, 32'hFFFF_FFFF, -1, 32'h0,         2, 608, 639, 1'b1, 55};
    vecs[5] = '{ 0, 32'h0000_0001, -1, 32'h0,         1, 0,   0,   1'b1, 51};

    clear_row();
    repeat (2) @(negedge i_clk);
    check("reset busy", int'(o_busy), 0);
    check("reset trig", int'(o_det_trig), 0);
    check("reset rd_en", int'(o_rd_en), 0);
    check("reset done", int'(o_done) + int'(o_err), 0);
    check("reset cols", int'(o_left_col) + int'(o_right_col) + int'(o_row_valid), 0);
    i_rstn = 1'b1;
    repeat (2) @(negedge i_clk);

    for (int t = 0; t < 6; t++) begin
      clear_row();
      if (vecs[t].w_a >= 0) row_mem[vecs[t].w_a] = vecs[t].d_a;
      if (vecs[t].w_b >= 0) row_mem[vecs[t].w_b] = vecs[t].d_b;
      run_row($sformatf("vec%0d", t), vecs[t].k, vecs[t].exp_l, vecs[t].exp_r,
              vecs[t].exp_v, vecs[t].exp_cyc, 1'b0);
    end

    for (int t = 0; t < 10; t++) begin
      int n, k;
      clear_row();
      n = $urandom_range(0, 3);
      for (int i = 0; i < n; i++)
        row_mem[$urandom_range(0, W-1)] = ($urandom_range(0, 1) != 0) ?
                                          (32'h1 << $urandom_range(0, 31)) : $urandom;
      k = $urandom_range(1, 4);
      model(l, r, v);
      run_row($sformatf("rand%0d", t), k, l, r, v, exp_cycles(l, r, v, k), 1'b0);
    end

    // Slow detector, i_start pulsed while busy and again in the DONE cycle.
    clear_row();
    row_mem[3] = 32'h0000_0100;
    run_row("late_start", 10, 104, 104, 1'b1, 87, 1'b1);

    // Reset asserted during the right-bound handshake.
    clear_row();
    row_mem[0]  = 32'h8000_0000;
    row_mem[19] = 32'h0000_0001;
    det_k = 5;
    @(negedge i_clk);
    done_pulses = 0;
    i_start = 1'b1;
    @(negedge i_clk);
    i_start = 1'b0;
    cyc = 0;
    while (!(o_det_trig && o_det_left_or_right) && cyc < 500) begin
      @(negedge i_clk);
      cyc++;
    end
    check("rst_mid reached R_TRIG", int'(cyc < 500), 1);
    #2 i_rstn = 1'b0;
    #1;
    check("rst_mid trig", int'(o_det_trig), 0);
    check("rst_mid busy", int'(o_busy) + int'(o_rd_en) + int'(o_done) + int'(o_err), 0);
    check("rst_mid det_data", int'(o_det_data) + int'(o_det_left_or_right), 0);
    check("rst_mid addr", int'(o_rd_addr), 0);
    check("rst_mid cols", int'(o_left_col) + int'(o_right_col) + int'(o_row_valid), 0);
    repeat (3) @(negedge i_clk);
    i_rstn = 1'b1;
    repeat (20) @(negedge i_clk);
    check("rst_mid no_done", done_pulses, 0);
    run_row("after_rst", 1, 31, 608, 1'b1, 13, 1'b0);

`ifdef ROW_BOUND_TIMEOUT_EN
    // Detector never answers: watchdog aborts the left handshake.
    clear_row();
    row_mem[3] = 32'h0000_0100;
    det_stuck = 1'b1;
    @(negedge i_clk);
    err_pulses = 0;
    i_start = 1'b1;
    @(negedge i_clk);
    i_start = 1'b0;
    cyc = 0;
    while (!o_det_trig && cyc < 200) begin
      @(negedge i_clk);
      cyc++;
    end
    cyc = 0;
    while (!o_err && cyc < 400) begin
      @(negedge i_clk);
      cyc++;
    end
    check("wd err_cycle", cyc, 255);
    check("wd trig_low", int'(o_det_trig), 0);
    @(negedge i_clk);
    check("wd done_next", int'(o_done), 1);
    check("wd row_valid", int'(o_row_valid), 0);
    check("wd cols", int'(o_left_col) + int'(o_right_col), 0);
    check("wd err_pulses", err_pulses, 1);
    det_stuck = 1'b0;
    repeat (16) @(negedge i_clk);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
